// File: rtl/rib_pkg.sv
// Shared RIB definitions: field widths, request header, decode-error data word, pending-state encoding.
// No logic; imported by the selector and its address decoder.
package rib_pkg;
  localparam int ADDR_W = 32;
  localparam int MASK_W = 4;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pend_st_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wrcs;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] wdata;
  } hdr_t;
endpackage

// File: rtl/rib_addr_dec.sv
// RIB address decoder: base/mask compare per slave, lowest index wins on overlap.
// Purely combinational, zero latency; no flow control.
module rib_addr_dec
  import rib_pkg::*;
#(
  parameter int                       SLAVES   = 4,
  parameter int                       IDX_W    = 2,
  parameter logic [ADDR_W*SLAVES-1:0] SLV_BASE = '0,
  parameter logic [ADDR_W*SLAVES-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [SLAVES-1:0] o_hit_oh,
  output logic [IDX_W-1:0]  o_hit_idx,
  output logic              o_hit_any
);
  always_comb begin
    o_hit_oh  = '0;
    o_hit_idx = '0;
    o_hit_any = 1'b0;
    // Walk downwards so the lowest matching slave is the last to overwrite.
    for (int k = SLAVES - 1; k >= 0; k--) begin
      if ((i_addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
        o_hit_oh    = '0;
        o_hit_oh[k] = 1'b1;
        o_hit_idx   = IDX_W'(k);
        o_hit_any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rib_slave_sel.sv
// RIB 1:N slave selector, one outstanding transaction; RIB_DECERR_EN adds an internal decode-error responder.
// Grant/response paths are combinational; i_ribs_rdy low holds the pending response and blocks new grants.
module rib_slave_sel
  import rib_pkg::*;
#(
  parameter int                       SLAVES   = 4,
  parameter logic [ADDR_W*SLAVES-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                  32'h1000_0000, 32'h0000_0000},
  parameter logic [ADDR_W*SLAVES-1:0] SLV_MASK = {4{32'hF000_0000}}
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [ADDR_W-1:0]        i_ribs_addr,
  input  logic                     i_ribs_wrcs,
  input  logic [MASK_W-1:0]        i_ribs_mask,
  input  logic [DATA_W-1:0]        i_ribs_wdata,
  input  logic                     i_ribs_req,
  output logic                     o_ribs_gnt,
  output logic                     o_ribs_rsp,
  output logic [DATA_W-1:0]        o_ribs_rdata,
  input  logic                     i_ribs_rdy,
  output logic [ADDR_W*SLAVES-1:0] o_slv_addr,
  output logic [SLAVES-1:0]        o_slv_wrcs,
  output logic [MASK_W*SLAVES-1:0] o_slv_mask,
  output logic [DATA_W*SLAVES-1:0] o_slv_wdata,
  output logic [SLAVES-1:0]        o_slv_req,
  input  logic [SLAVES-1:0]        i_slv_gnt,
  input  logic [SLAVES-1:0]        i_slv_rsp,
  input  logic [DATA_W*SLAVES-1:0] i_slv_rdata,
  output logic [SLAVES-1:0]        o_slv_rdy
`ifdef RIB_DECERR_EN
  ,
  output logic                     o_decerr
`endif
);
  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  hdr_t              ribs_hdr;
  logic [SLAVES-1:0] hit_oh;
  logic [SLAVES-1:0] route_oh;
  logic [IDX_W-1:0]  hit_idx;
  logic              hit_any;
  pend_st_e          state_q, state_d;
  logic [IDX_W-1:0]  pend_id_q, pend_id_d;
  logic              pend_vld, pend_rsp, pend_slv, rsp_sel, to_slv, gnt_src, done, accept, hs;
  logic [DATA_W-1:0] rdata_sel;
`ifdef RIB_DECERR_EN
  logic              pend_err_q, pend_err_d;
`endif

  assign ribs_hdr    = '{addr: i_ribs_addr, wrcs: i_ribs_wrcs, mask: i_ribs_mask, wdata: i_ribs_wdata};
  assign o_slv_addr  = {SLAVES{ribs_hdr.addr}};
  assign o_slv_wrcs  = {SLAVES{ribs_hdr.wrcs}};
  assign o_slv_mask  = {SLAVES{ribs_hdr.mask}};
  assign o_slv_wdata = {SLAVES{ribs_hdr.wdata}};

  rib_addr_dec #(
    .SLAVES   (SLAVES),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_addr_dec (
    .i_addr    (ribs_hdr.addr),
    .o_hit_oh  (hit_oh),
    .o_hit_idx (hit_idx),
    .o_hit_any (hit_any)
  );

  always_comb begin
    state_d   = state_q;
    pend_id_d = pend_id_q;
    pend_vld  = (state_q == ST_PEND);
    rsp_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < SLAVES; k++) begin
      if (pend_id_q == IDX_W'(k)) begin
        rsp_sel   = i_slv_rsp[k];
        rdata_sel = i_slv_rdata[k*DATA_W +: DATA_W];
      end
    end
`ifdef RIB_DECERR_EN
    // A miss is absorbed here: no slave request, the response is the error word.
    pend_err_d   = pend_err_q;
    pend_slv     = ~pend_err_q;
    to_slv       = hit_any;
    route_oh     = hit_oh;
    pend_rsp     = pend_vld & (pend_err_q | rsp_sel);
    o_ribs_rdata = pend_err_q ? ERR_RDATA : rdata_sel;
`else
    // Without the error responder a miss falls through to slave 0.
    pend_slv     = 1'b1;
    to_slv       = 1'b1;
    route_oh     = hit_any ? hit_oh : SLAVES'(1);
    pend_rsp     = pend_vld & rsp_sel;
    o_ribs_rdata = rdata_sel;
`endif
    gnt_src    = to_slv ? |(i_slv_gnt & route_oh) : 1'b1;
    done       = pend_rsp & i_ribs_rdy;
    accept     = ~pend_vld | done;
    hs         = i_rst & i_ribs_req & accept & gnt_src;
    o_ribs_gnt = hs;
    o_ribs_rsp = i_rst & pend_rsp;
    o_slv_req  = (i_rst & i_ribs_req & accept & to_slv) ? route_oh : '0;
    o_slv_rdy  = '0;
    for (int k = 0; k < SLAVES; k++) begin
      o_slv_rdy[k] = i_rst & pend_vld & pend_slv & i_ribs_rdy & (pend_id_q == IDX_W'(k));
    end
`ifdef RIB_DECERR_EN
    o_decerr = i_rst & pend_vld & pend_err_q & i_ribs_rdy;
`endif
    // A completing response and a new handshake in the same cycle keep us in PEND.
    if (hs) begin
      state_d   = ST_PEND;
      pend_id_d = hit_idx;
`ifdef RIB_DECERR_EN
      pend_err_d = ~hit_any;
`endif
    end else if (done) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      pend_id_q  <= '0;
`ifdef RIB_DECERR_EN
      pend_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pend_id_q  <= pend_id_d;
`ifdef RIB_DECERR_EN
      pend_err_q <= pend_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_rib_slave_sel.sv
// Bench for rib_slave_sel: slave models answer one cycle after grant, scoreboard holds expected responses.
// Honours RIB_DECERR_EN the same way the design does.
module tb_rib_slave_sel;
`ifdef RIB_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [31:0]  i_ribs_addr;
  logic         i_ribs_wrcs;
  logic [3:0]   i_ribs_mask;
  logic [31:0]  i_ribs_wdata;
  logic         i_ribs_req;
  logic         o_ribs_gnt;
  logic         o_ribs_rsp;
  logic [31:0]  o_ribs_rdata;
  logic         i_ribs_rdy;
  logic [127:0] o_slv_addr;
  logic [3:0]   o_slv_wrcs;
  logic [15:0]  o_slv_mask;
  logic [127:0] o_slv_wdata;
  logic [3:0]   o_slv_req;
  logic [3:0]   i_slv_gnt;
  logic [3:0]   i_slv_rsp;
  logic [127:0] i_slv_rdata;
  logic [3:0]   o_slv_rdy;
`ifdef RIB_DECERR_EN
  logic         o_decerr;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_gnt = 0;
  logic [3:0]  rsp_pend, mute, force_rsp, slv_flush;
  logic [31:0] rdata_r [4];

  rib_slave_sel dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ribs_addr  (i_ribs_addr),
    .i_ribs_wrcs  (i_ribs_wrcs),
    .i_ribs_mask  (i_ribs_mask),
    .i_ribs_wdata (i_ribs_wdata),
    .i_ribs_req   (i_ribs_req),
    .o_ribs_gnt   (o_ribs_gnt),
    .o_ribs_rsp   (o_ribs_rsp),
    .o_ribs_rdata (o_ribs_rdata),
    .i_ribs_rdy   (i_ribs_rdy),
    .o_slv_addr   (o_slv_addr),
    .o_slv_wrcs   (o_slv_wrcs),
    .o_slv_mask   (o_slv_mask),
    .o_slv_wdata  (o_slv_wdata),
    .o_slv_req    (o_slv_req),
    .i_slv_gnt    (i_slv_gnt),
    .i_slv_rsp    (i_slv_rsp),
    .i_slv_rdata  (i_slv_rdata),
    .o_slv_rdy    (o_slv_rdy)
`ifdef RIB_DECERR_EN
    ,
    .o_decerr     (o_decerr)
`endif
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_data(input int k, input logic [31:0] a);
    return a + 32'h0234_5668 + 32'((k ^ 1) << 8);
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h want %h", tag, act, exp);
    else n_pass++;
  endtask

  // Slave models: accept on req&gnt, answer next cycle, hold rsp until rdy.
  always_comb begin
    i_slv_rdata = '0;
    i_slv_rsp   = (rsp_pend & ~mute) | force_rsp;
    for (int k = 0; k < 4; k++)
      i_slv_rdata[k*32 +: 32] = rsp_pend[k] ? rdata_r[k] : (32'hBAD0_0000 | 32'(k));
  end

  always @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (slv_flush[k] || (i_slv_rsp[k] && o_slv_rdy[k])) rsp_pend[k] <= 1'b0;
      if (o_slv_req[k] && i_slv_gnt[k]) begin
        rsp_pend[k] <= 1'b1;
        rdata_r[k]  <= exp_data(k, o_slv_addr[k*32 +: 32]);
      end
    end
  end

  always @(negedge i_clk) begin
    if (o_ribs_rsp === 1'b1 && i_ribs_rdy) begin
      if (sb_q.size() == 0) begin
        chk("unexp_rsp", 64'(o_ribs_rsp), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_rdata", 64'(o_ribs_rdata), 64'(mon_e.rdata));
`ifdef RIB_DECERR_EN
        chk("sb_decerr", 64'(o_decerr), 64'(mon_e.err));
`endif
      end
    end
  end

  task automatic send(input logic [31:0] a, input int k, input bit err, input bit push, output int waited);
    i_ribs_addr  = a;
    i_ribs_wrcs  = 1'b0;
    i_ribs_mask  = 4'hF;
    i_ribs_wdata = ~a;
    i_ribs_req   = 1'b1;
    if (push) sb_q.push_back(err ? exp_t'{32'hDEAD_BEEF, 1'b1} : exp_t'{exp_data(k, a), 1'b0});
    waited = 0;
    @(negedge i_clk);
    while (!o_ribs_gnt && waited < 20) begin
      waited++;
      @(negedge i_clk);
    end
    chk("gnt", 64'(o_ribs_gnt), 64'd1);
    chk("slv_req", 64'(o_slv_req), err ? 64'd0 : (64'd1 << k));
    chk("slv_addr", 64'(o_slv_addr[k*32 +: 32]), 64'(a));
    last_gnt = cyc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int w, g0, g1, gfirst, k;
    logic [31:0] a;
    i_rst = 1'b0; i_ribs_req = 1'b1; i_ribs_addr = 32'h1000_0000; i_ribs_wrcs = 1'b0;
    i_ribs_mask = 4'hF; i_ribs_wdata = '0; i_ribs_rdy = 1'b1; i_slv_gnt = 4'hF;
    mute = '0; force_rsp = '0; slv_flush = 4'hF;
    repeat (2) @(posedge i_clk);
    #1 slv_flush = '0;
    @(negedge i_clk);
    chk("rst_gnt", 64'(o_ribs_gnt), 64'd0);
    chk("rst_req", 64'(o_slv_req), 64'd0);
    chk("rst_rsp", 64'(o_ribs_rsp), 64'd0);
    chk("rst_rdy", 64'(o_slv_rdy), 64'd0);
`ifdef RIB_DECERR_EN
    chk("rst_decerr", 64'(o_decerr), 64'd0);
`endif
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_ribs_req = 1'b0;

    // Single read to slave 1
    send(32'h1000_0010, 1, 1'b0, 1'b1, w);
    i_ribs_req = 1'b0;
    @(negedge i_clk);
    chk("rd_rsp", 64'(o_ribs_rsp), 64'd1);
    chk("rd_rdata", 64'(o_ribs_rdata), 64'h1234_5678);
    chk("rd_rdy", 64'(o_slv_rdy), 64'b0010);
    @(posedge i_clk); #1;

    // Back-to-back slave 0 then slave 2
    send(32'h0000_0000, 0, 1'b0, 1'b1, w); g0 = last_gnt;
    send(32'h2000_0000, 2, 1'b0, 1'b1, w); g1 = last_gnt;
    i_ribs_req = 1'b0;
    chk("b2b_gap", 64'(g1 - g0), 64'd1);
    drain();

    // Slave 2 response stalled by upstream, queued request to slave 0
    send(32'h2000_0004, 2, 1'b0, 1'b1, w);
    i_ribs_rdy = 1'b0;
    i_ribs_addr = 32'h0000_0008; i_ribs_wdata = ~i_ribs_addr; i_ribs_req = 1'b1;
    sb_q.push_back(exp_t'{exp_data(0, 32'h0000_0008), 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("hold_gnt", 64'(o_ribs_gnt), 64'd0);
      chk("hold_rsp", 64'(o_ribs_rsp), 64'd1);
      @(posedge i_clk); #1;
    end
    i_ribs_rdy = 1'b1;
    @(negedge i_clk);
    chk("rdy_gnt", 64'(o_ribs_gnt), 64'd1);
    chk("rdy_req", 64'(o_slv_req), 64'b0001);
    @(posedge i_clk); #1;
    i_ribs_req = 1'b0;
    drain();

    // Unsolicited slave 1 response while slave 0 is pending
    mute[0] = 1'b1;
    send(32'h0000_0040, 0, 1'b0, 1'b1, w);
    i_ribs_req = 1'b0; force_rsp = 4'b0010;
    @(negedge i_clk);
    chk("unsol_rsp", 64'(o_ribs_rsp), 64'd0);
    chk("unsol_rdy", 64'(o_slv_rdy), 64'b0001);
    @(posedge i_clk); #1;
    mute[0] = 1'b0;
    @(negedge i_clk);
    chk("sel_rsp", 64'(o_ribs_rsp), 64'd1);
    chk("sel_rdata", 64'(o_ribs_rdata), 64'(exp_data(0, 32'h0000_0040)));
    @(posedge i_clk); #1;
    force_rsp = '0;
    drain();

    // Unmapped address
    send(32'h8000_0000, 0, DEC, 1'b1, w);
    i_ribs_req = 1'b0;
    @(negedge i_clk);
    chk("miss_rsp", 64'(o_ribs_rsp), 64'd1);
    @(posedge i_clk); #1;
    drain();

    // Reset while pending on slave 3, slave answers after release
    mute[3] = 1'b1;
    send(32'h3000_0000, 3, 1'b0, 1'b0, w);
    i_ribs_req = 1'b0; i_rst = 1'b0;
    @(negedge i_clk);
    chk("rstp_rsp", 64'(o_ribs_rsp), 64'd0);
    chk("rstp_rdy", 64'(o_slv_rdy), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1; mute[3] = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      chk("late_rsp", 64'(o_ribs_rsp), 64'd0);
      chk("late_rdy", 64'(o_slv_rdy), 64'd0);
      @(posedge i_clk); #1;
    end
    send(32'h1000_0000, 1, 1'b0, 1'b1, w);
    chk("post_rst_wait", 64'(w), 64'd0);
    i_ribs_req = 1'b0; slv_flush = 4'b1000;
    @(posedge i_clk); #1;
    slv_flush = '0;
    drain();

    // Random back-to-back burst across all slaves
    gfirst = 0;
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 3);
      a = (32'(k) << 28) | ($urandom & 32'h0FFF_FFFF);
      send(a, k, 1'b0, 1'b1, w);
      if (i == 0) gfirst = last_gnt;
    end
    i_ribs_req = 1'b0;
    chk("burst_rate", 64'(last_gnt - gfirst), 64'd15);
    drain();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
